// File: rtl/ie_exec_unit.sv
// ie_exec_unit: pipelined execute stage with a valid/ready handshake.
// Single-cycle ALU ops, iterative radix-2 shift-add multiply, and registered result/flags.
module ie_exec_unit #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CntLast = SW'(WIDTH - 1);

  typedef enum logic [0:0] {StIdle, StMul} state_e;

  state_e           state_q;
  logic [SW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;

  logic             accept;
  logic             is_mul;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic [WIDTH-1:0] mul_prod;

  // A new op may start only from idle, and only if the output slot is free or draining now.
  assign in_ready = (state_q == StIdle) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (MUL_EN != 0) && (opcode == 4'hA);
  assign sum      = {1'b0, data1} + {1'b0, data2};
  assign diff     = {1'b0, data1} - {1'b0, data2};
  assign shamt    = data2[SW-1:0];
  // Partial product including the current multiplier bit; final value on the last step.
  assign mul_prod = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle ALU result and carry/overflow for the op currently presented.
  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (opcode)
      4'h0: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (data1[WIDTH-1] == data2[WIDTH-1]) && (sum[WIDTH-1] != data1[WIDTH-1]);
      end
      4'h1: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];  // borrow: set exactly when A < B unsigned
        alu_v   = (data1[WIDTH-1] != data2[WIDTH-1]) && (diff[WIDTH-1] != data1[WIDTH-1]);
      end
      4'h2: alu_res = data1 & data2;
      4'h3: alu_res = data1 | data2;
      4'h4: alu_res = data1 ^ data2;
      4'h5: alu_res = data1 << shamt;
      4'h6: alu_res = data1 >> shamt;
      4'h7: alu_res = WIDTH'($signed(data1) >>> shamt);
      4'h8: alu_res = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
      4'h9: alu_res = {{(WIDTH-1){1'b0}}, (data1 < data2)};
      4'hB: alu_res = data2;
      default: alu_res = '0;
    endcase
  end

  // Control FSM plus registered result/flags/out_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (is_mul) begin
              mcand_q   <= data1;
              mplier_q  <= data2;
              acc_q     <= '0;
              cnt_q     <= '0;
              out_valid <= 1'b0;  // accept implies the old result is gone or draining
              state_q   <= StMul;
            end else begin
              result    <= alu_res;
              flags     <= {alu_v, alu_c, alu_res[WIDTH-1], (alu_res == '0)};
              out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        StMul: begin
          acc_q    <= mul_prod;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (out_ready) begin
            out_valid <= 1'b0;
          end
          if (cnt_q == CntLast) begin
            result    <= mul_prod;
            flags     <= {2'b00, mul_prod[WIDTH-1], (mul_prod == '0)};
            out_valid <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ie_exec_unit.sv
// Self-checking bench for ie_exec_unit: scoreboard of expected results plus directed
// latency, back-pressure, reset and MUL_EN=0 checks.
module tb_ie_exec_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data1;
  logic [15:0] data2;
  logic [3:0]  opcode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [3:0]  flags;

  // Second instance built without the multiplier.
  logic        in_valid2;
  logic        in_ready2;
  logic [15:0] data1_2;
  logic [15:0] data2_2;
  logic [3:0]  opcode2;
  logic        out_valid2;
  logic        out_ready2;
  logic [15:0] result2;
  logic [3:0]  flags2;

  int unsigned n_checks;
  int unsigned n_pass;
  logic [19:0] sb_q[$];

  ie_exec_unit #(.WIDTH(16), .MUL_EN(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data1    (data1),
    .data2    (data2),
    .opcode   (opcode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags)
  );

  ie_exec_unit #(.WIDTH(16), .MUL_EN(0)) dut_nomul (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid2),
    .in_ready (in_ready2),
    .data1    (data1_2),
    .data2    (data2_2),
    .opcode   (opcode2),
    .out_valid(out_valid2),
    .out_ready(out_ready2),
    .result   (result2),
    .flags    (flags2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: returns {V,C,N,Z, result[15:0]} using plain integer arithmetic.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [3:0] op, input bit mul_en);
    int unsigned ua;
    int unsigned ub;
    int          sa;
    int          sbv;
    int          s;
    logic [31:0] t;
    logic [15:0] r;
    logic        c;
    logic        v;
    ua  = a;
    ub  = b;
    sa  = $signed(a);
    sbv = $signed(b);
    c   = 1'b0;
    v   = 1'b0;
    t   = '0;
    case (op)
      4'h0: begin t = ua + ub; c = (t > 32'd65535); s = sa + sbv; v = (s > 32767) || (s < -32768); end
      4'h1: begin t = ua - ub; c = (ua < ub); s = sa - sbv; v = (s > 32767) || (s < -32768); end
      4'h2: t = {16'h0, a & b};
      4'h3: t = {16'h0, a | b};
      4'h4: t = {16'h0, a ^ b};
      4'h5: t = ua << b[3:0];
      4'h6: t = ua >> b[3:0];
      4'h7: t = sa >>> b[3:0];
      4'h8: t = (sa < sbv) ? 32'd1 : 32'd0;
      4'h9: t = (ua < ub) ? 32'd1 : 32'd0;
      4'hA: t = mul_en ? ua * ub : 32'd0;
      4'hB: t = ub;
      default: t = 32'd0;
    endcase
    r = t[15:0];
    return {v, c, r[15], (r == 16'h0), r};
  endfunction

  // Present one op, wait (bounded) for in_ready, record the expectation, complete the accept.
  // Entered and left just after a rising edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    data1    = a;
    data2    = b;
    opcode   = op;
    while (!in_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
    else sb_q.push_back(model(a, b, op, 1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic [3:0]  rop;
    logic [19:0] e2;
    logic [3:0]  nm_ops[2];

    n_checks   = 0;
    n_pass     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    data1      = '0;
    data2      = '0;
    opcode     = '0;
    out_ready  = 1'b1;
    in_valid2  = 1'b0;
    data1_2    = '0;
    data2_2    = '0;
    opcode2    = '0;
    out_ready2 = 1'b1;

    // Scoreboard monitor: a transfer happens on the edge after a cycle with valid && ready.
    fork
      forever begin
        logic [19:0] exp;
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("sb_unexpected", 32'd1, 32'd0);
          end else begin
            exp = sb_q.pop_front();
            check("sb_result", 32'(result), 32'(exp[15:0]));
            check("sb_flags", 32'(flags), 32'(exp[19:16]));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // ADD with signed overflow, latency 1.
    send(16'h7FFF, 16'h0001, 4'h0);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_result", 32'(result), 32'h8000);
    check("add_flags", 32'(flags), 32'hA);

    // Back-to-back SUB, SRA, SLT at full throughput.
    send(16'h0003, 16'h0005, 4'h1);
    check("b2b_sub_valid", 32'(out_valid), 32'd1);
    send(16'h8000, 16'h0004, 4'h7);
    check("b2b_sra_valid", 32'(out_valid), 32'd1);
    send(16'hFFFF, 16'h0001, 4'h8);
    check("b2b_slt_valid", 32'(out_valid), 32'd1);
    check("b2b_slt_result", 32'(result), 32'h0001);

    // MUL: in_ready low and no result for 16 cycles, product on the 16th edge.
    send(16'h0123, 16'h0045, 4'hA);
    for (int i = 0; i < 16; i++) begin
      check("mul_busy_ready", 32'(in_ready), 32'd0);
      check("mul_busy_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    check("mul_done_valid", 32'(out_valid), 32'd1);
    check("mul_done_result", 32'(result), 32'h4E6F);
    drain();

    // Back-pressure: result held for 5 cycles, then drain and accept on the same edge.
    out_ready = 1'b0;
    send(16'hAAAA, 16'h5555, 4'h4);
    in_valid = 1'b1;
    data1    = 16'h1234;
    data2    = 16'h0F0F;
    opcode   = 4'h3;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_result", 32'(result), 32'hFFFF);
      check("bp_flags", 32'(flags), 32'h2);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    send(16'h1234, 16'h0F0F, 4'h3);
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_result", 32'(result), 32'h1F3F);
    drain();

    // Reset in the middle of a multiply (counter at 7).
    send(16'h0123, 16'h0045, 4'hA);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    send(16'h0002, 16'h0002, 4'h0);
    check("post_rst_add", 32'(result), 32'h0004);
    check("post_rst_flags", 32'(flags), 32'h0);

    // Remaining opcodes, then a random mix including MUL and undefined codes.
    send(16'h00F1, 16'h0004, 4'h5);
    send(16'hF100, 16'h0008, 4'h6);
    send(16'h0001, 16'hFFFF, 4'h9);
    send(16'h1111, 16'hBEEF, 4'hB);
    send(16'hFFFF, 16'hFFFF, 4'hF);
    send(16'h0000, 16'h0001, 4'h1);
    for (int i = 0; i < 40; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rop = 4'($urandom_range(0, 15));
      send(ra, rb, rop);
    end
    drain();

    // MUL_EN=0 build: 0xA and 0xF give 0 with Z set, single-cycle latency.
    nm_ops[0] = 4'hA;
    nm_ops[1] = 4'hF;
    for (int i = 0; i < 2; i++) begin
      in_valid2 = 1'b1;
      data1_2   = 16'h0123;
      data2_2   = 16'h0045;
      opcode2   = nm_ops[i];
      e2        = model(16'h0123, 16'h0045, nm_ops[i], 1'b0);
      check("nomul_in_ready", 32'(in_ready2), 32'd1);
      @(posedge clk);
      #1;
      in_valid2 = 1'b0;
      check("nomul_valid", 32'(out_valid2), 32'd1);
      check("nomul_result", 32'(result2), 32'(e2[15:0]));
      check("nomul_flags", 32'(flags2), 32'(e2[19:16]));
    end

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ie_exec_unit.md
# ie_exec_unit

Parametrised execute stage for the pipelined datapath. Takes one operand pair and a 4-bit opcode per transaction over a valid/ready handshake and returns a registered result plus status flags. Extends the basic ADD/SUB/AND/OR/XOR execute stage with shifts, compares, an iterative multi-cycle multiply, and downstream back-pressure.

## Interface
- WIDTH, 16, operand/result width; must be at least 4 and a power of two.
- MUL_EN, 1, 1 enables the iterative multiplier; 0 makes opcode 0xA behave as undefined.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand/opcode presented.
- in_ready  out  1  stage can accept; combinational: (state==IDLE) && (!out_valid || out_ready).
- data1  in  WIDTH  operand A.
- data2  in  WIDTH  operand B; low log2(WIDTH) bits are the shift amount for shifts.
- opcode  in  4  operation select.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  downstream accepts the result.
- result  out  WIDTH  registered result.
- flags  out  4  {V,C,N,Z}, registered with result.

## Operation
- Opcodes:
  - 0x0 ADD.
  - 0x1 SUB (A−B).
  - 0x2 AND.
  - 0x3 OR.
  - 0x4 XOR.
  - 0x5 SHL (logical left).
  - 0x6 SHR (logical right).
  - 0x7 SRA (arithmetic right).
  - 0x8 SLT (signed A<B → 1, else 0).
  - 0x9 SLTU (unsigned).
  - 0xA MUL (low WIDTH bits of A×B).
  - 0xB PASS (result = B).
  - 0xC–0xF, and 0xA when MUL_EN=0: result 0, single-cycle.
- All arithmetic is modulo 2^WIDTH.
- Flags:
  - Z = (result==0).
  - N = result[WIDTH-1].
  - C = carry-out for ADD, borrow (A<B unsigned) for SUB, 0 otherwise.
  - V = signed overflow for ADD/SUB, 0 otherwise.
- FSM states: IDLE, MUL.
  - IDLE: on accept (in_valid && in_ready) of a non-MUL op, load result/flags and set out_valid at the same edge. On accept of MUL, latch the operands, clear the accumulator and counter, and go to MUL.
  - MUL: radix-2 shift-add, one multiplier bit per cycle; counter 0..WIDTH-1. At the edge where counter==WIDTH-1, load the product into result, set out_valid, and return to IDLE.
  - in_ready is 0 throughout MUL.
- Output hold: while out_valid && !out_ready, result, flags and out_valid stay unchanged. in_ready is 0, so no new operation starts.
- Drain: out_valid clears on an edge with out_ready=1 and no new accept.
- Simultaneous events:
  - out_ready=1 and a single-cycle accept on the same edge: the new result replaces the old one and out_valid stays 1. This sustains full throughput of 1 op/cycle.
  - out_ready=1 and a MUL accept on the same edge: the old result drains, out_valid=0 until the product is ready.
- Reset (any time, including mid-MUL): state=IDLE, counter=0, out_valid=0, result=0, flags=0. Any in-flight multiply is discarded. in_ready reads 1 as soon as rst deasserts.

## Timing
- Single-cycle ops: result visible the cycle after the accept edge (latency 1).
- MUL: result visible WIDTH cycles after the accept edge (latency WIDTH).
- Maximum MUL throughput is 1 per WIDTH+1 cycles when out_ready is held high.
- No combinational path from data1/data2/opcode to any output. in_ready depends combinationally on out_ready only.

## Test plan
- Reset then ADD 0x7FFF+0x0001 (WIDTH=16) → result 0x8000, flags V=1 C=0 N=1 Z=0, out_valid 1 cycle after accept.
- Back-to-back with out_ready=1: SUB 0x0003−0x0005, SRA 0x8000>>4, SLT 0xFFFF,0x0001 → results 0xFFFE (C=1,N=1), 0xF800, 0x0001 on three consecutive cycles.
- MUL 0x0123×0x0045 → result 0x4E6F exactly 16 cycles after accept; in_ready low for those 16 cycles.
- Back-pressure: hold out_ready=0 for 5 cycles after XOR 0xAAAA^0x5555 → result 0xFFFF held stable, in_ready=0. Release → drains, next op accepted the same edge.
- Assert rst at MUL counter=7 → out_valid=0, result 0, in_ready=1 after release. A following ADD 2+2 returns 4 with Z=0.
- MUL_EN=0 build: opcode 0xA and 0xF each give result 0, Z=1, single-cycle latency.
